// File: rtl/simon_seq_ctrl.sv
// Sequence-game controller for the Simon Says datapath: generates one new symbol per level,
// replays the sequence, times and validates player input, and tracks level, step and lives.
module simon_seq_ctrl #(
  parameter int MAX_LEVEL      = 10,
  parameter int LVL_W          = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int LIVES          = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             blinker_done,
  input  logic             input_done,
  input  logic             cmp_good,
  output logic             getRandNum,
  output logic             rw_mem,
  output logic             on_cmp,
  output logic             on_input_block,
  output logic             on_blinker,
  output logic [LVL_W-1:0] mem_addr,
  output logic [LVL_W-1:0] out_level,
  output logic [LVL_W-1:0] out_step,
  output logic [2:0]       lives_left,
  output logic             win,
  output logic             lose,
  output logic             timeout_err
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [LVL_W-1:0] MAX_LVL    = LVL_W'(MAX_LEVEL);
  localparam logic [2:0]       LIVES_INIT = 3'(LIVES);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_BLINK,
    S_INPUT,
    S_VALIDATE,
    S_WIN,
    S_LOSE
  } state_e;

  state_e            state_q, state_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [LVL_W-1:0]  step_q,  step_d;
  logic [2:0]        lives_q, lives_d;
  logic [TMR_W-1:0]  tmr_q,   tmr_d;

  logic              fail;
  logic              tmr_expired;
  logic [LVL_W-1:0]  step_inc;

  assign tmr_expired = (tmr_q == TMR_LAST);
  // step never exceeds level-1, so step+1 fits in LVL_W bits.
  assign step_inc    = step_q + LVL_W'(1);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    step_d  = step_q;
    lives_d = lives_q;
    tmr_d   = tmr_q;
    fail    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_GEN;
          level_d = '0;
          step_d  = '0;
          lives_d = LIVES_INIT;
        end
      end
      S_GEN: begin
        state_d = S_BLINK;
        level_d = level_q + LVL_W'(1);
        step_d  = '0;
      end
      S_BLINK: begin
        if (blinker_done) begin
          state_d = S_INPUT;
          tmr_d   = '0;
        end
      end
      S_INPUT: begin
        if (!tmr_expired) tmr_d = tmr_q + TMR_W'(1);
        if (input_done)       state_d = S_VALIDATE;
        else if (tmr_expired) fail    = 1'b1;
      end
      S_VALIDATE: begin
        if (!cmp_good) begin
          fail = 1'b1;
        end else if (step_inc < level_q) begin
          state_d = S_INPUT;
          step_d  = step_inc;
          tmr_d   = '0;
        end else if (level_q < MAX_LVL) begin
          state_d = S_GEN;
        end else begin
          state_d = S_WIN;
        end
      end
      S_WIN, S_LOSE: begin
        if (start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A failure costs a life and replays the current level, or ends the game on the last life.
    if (fail) begin
      lives_d = lives_q - 3'd1;
      step_d  = '0;
      state_d = (lives_q == 3'd1) ? S_LOSE : S_BLINK;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      level_q <= '0;
      step_q  <= '0;
      lives_q <= LIVES_INIT;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      step_q  <= step_d;
      lives_q <= lives_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    getRandNum     = 1'b0;
    rw_mem         = 1'b0;
    on_cmp         = 1'b0;
    on_input_block = 1'b0;
    on_blinker     = 1'b0;
    mem_addr       = '0;
    win            = 1'b0;
    lose           = 1'b0;
    timeout_err    = 1'b0;

    unique case (state_q)
      S_GEN: begin
        getRandNum = 1'b1;
        rw_mem     = 1'b1;
        mem_addr   = level_q;
      end
      S_BLINK: on_blinker = 1'b1;
      S_INPUT: begin
        on_input_block = 1'b1;
        mem_addr       = step_q;
        timeout_err    = tmr_expired && !input_done;
      end
      S_VALIDATE: begin
        on_cmp   = 1'b1;
        mem_addr = step_q;
      end
      S_WIN:   win  = 1'b1;
      S_LOSE:  lose = 1'b1;
      default: ;
    endcase
  end

  assign out_level  = level_q;
  assign out_step   = step_q;
  assign lives_left = lives_q;

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Directed bench for simon_seq_ctrl: instance A (MAX_LEVEL=5, LIVES=3, TIMEOUT=5) and
// instance B (MAX_LEVEL=3, LIVES=1, TIMEOUT=5); sel routes stimulus and observation.
module tb_simon_seq_ctrl;

  localparam int LVL_W = 4;

  // Activity vector: {win, lose, on_cmp, on_input_block, on_blinker, rw_mem, getRandNum}
  localparam logic [6:0] P_IDLE  = 7'b0000000;
  localparam logic [6:0] P_GEN   = 7'b0000011;
  localparam logic [6:0] P_BLINK = 7'b0000100;
  localparam logic [6:0] P_INPUT = 7'b0001000;
  localparam logic [6:0] P_VAL   = 7'b0010000;
  localparam logic [6:0] P_WIN   = 7'b1000000;
  localparam logic [6:0] P_LOSE  = 7'b0100000;

  logic clk = 1'b0;
  logic reset;
  logic sel;
  logic start, blinker_done, input_done, cmp_good;

  logic a_get, a_rw, a_cmp, a_inb, a_blk, a_win, a_lose, a_tmo;
  logic b_get, b_rw, b_cmp, b_inb, b_blk, b_win, b_lose, b_tmo;
  logic [LVL_W-1:0] a_addr, a_lvl, a_stp, b_addr, b_lvl, b_stp;
  logic [2:0] a_lives, b_lives;

  logic [6:0]       phase;
  logic [LVL_W-1:0] addr, lvl_o, stp;
  logic [2:0]       lives;
  logic             tmo;

  int total = 0;
  int bad   = 0;
  int a_gen_cnt = 0;
  int b_gen_cnt = 0;
  int snap;

  always #5 clk = ~clk;

  simon_seq_ctrl #(.MAX_LEVEL(5), .LVL_W(LVL_W), .TIMEOUT_CYCLES(5), .LIVES(3)) u_a (
    .clk(clk), .reset(reset),
    .start(start && !sel), .blinker_done(blinker_done && !sel),
    .input_done(input_done && !sel), .cmp_good(cmp_good),
    .getRandNum(a_get), .rw_mem(a_rw), .on_cmp(a_cmp), .on_input_block(a_inb),
    .on_blinker(a_blk), .mem_addr(a_addr), .out_level(a_lvl), .out_step(a_stp),
    .lives_left(a_lives), .win(a_win), .lose(a_lose), .timeout_err(a_tmo)
  );

  simon_seq_ctrl #(.MAX_LEVEL(3), .LVL_W(LVL_W), .TIMEOUT_CYCLES(5), .LIVES(1)) u_b (
    .clk(clk), .reset(reset),
    .start(start && sel), .blinker_done(blinker_done && sel),
    .input_done(input_done && sel), .cmp_good(cmp_good),
    .getRandNum(b_get), .rw_mem(b_rw), .on_cmp(b_cmp), .on_input_block(b_inb),
    .on_blinker(b_blk), .mem_addr(b_addr), .out_level(b_lvl), .out_step(b_stp),
    .lives_left(b_lives), .win(b_win), .lose(b_lose), .timeout_err(b_tmo)
  );

  assign phase = sel ? {b_win, b_lose, b_cmp, b_inb, b_blk, b_rw, b_get}
                     : {a_win, a_lose, a_cmp, a_inb, a_blk, a_rw, a_get};
  assign addr  = sel ? b_addr  : a_addr;
  assign lvl_o = sel ? b_lvl   : a_lvl;
  assign stp   = sel ? b_stp   : a_stp;
  assign lives = sel ? b_lives : a_lives;
  assign tmo   = sel ? b_tmo   : a_tmo;

  always @(negedge clk) begin
    if (a_rw) a_gen_cnt <= a_gen_cnt + 1;
    if (b_rw) b_gen_cnt <= b_gen_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Entered in GEN for level lvl-1; plays one all-correct round and returns at the next state.
  task automatic do_round(input int lvl);
    check("gen_phase", 32'(phase), 32'(P_GEN));
    check("gen_addr", 32'(addr), lvl - 1);
    tick();
    check("blink_phase", 32'(phase), 32'(P_BLINK));
    check("blink_level", 32'(lvl_o), lvl);
    blinker_done = 1'b1;
    tick();
    blinker_done = 1'b0;
    for (int s = 0; s < lvl; s++) begin
      check("in_phase", 32'(phase), 32'(P_INPUT));
      check("in_addr", 32'(addr), s);
      check("in_step", 32'(stp), s);
      input_done = 1'b1;
      tick();
      input_done = 1'b0;
      check("val_phase", 32'(phase), 32'(P_VAL));
      check("val_addr", 32'(addr), s);
      tick();
    end
  endtask

  initial begin
    reset = 1'b0; sel = 1'b0;
    start = 1'b0; blinker_done = 1'b0; input_done = 1'b0; cmp_good = 1'b1;
    tick();
    tick();
    check("rst_a_phase", 32'(phase), 32'(P_IDLE));
    check("rst_a_lives", 32'(lives), 3);
    check("rst_a_level", 32'(lvl_o), 0);
    check("rst_a_tmo",   32'(tmo), 0);
    sel = 1'b1;
    #1;
    check("rst_b_phase", 32'(phase), 32'(P_IDLE));
    check("rst_b_lives", 32'(lives), 1);
    reset = 1'b1;
    tick();
    check("idle_hold", 32'(phase), 32'(P_IDLE));

    // B: MAX_LEVEL=3 clean game to WIN
    snap = b_gen_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    do_round(1);
    do_round(2);
    do_round(3);
    check("win_phase", 32'(phase), 32'(P_WIN));
    check("win_gen_pulses", b_gen_cnt - snap, 3);
    start = 1'b1;
    tick();
    check("win_to_idle", 32'(phase), 32'(P_IDLE));
    tick();
    check("new_game_gen", 32'(phase), 32'(P_GEN));
    check("new_game_level", 32'(lvl_o), 0);
    start = 1'b0;

    // B: LIVES=1, single mismatch loses
    tick();
    blinker_done = 1'b1;
    tick();
    blinker_done = 1'b0;
    input_done = 1'b1;
    tick();
    input_done = 1'b0;
    check("b_val", 32'(phase), 32'(P_VAL));
    cmp_good = 1'b0;
    tick();
    cmp_good = 1'b1;
    check("lose_phase", 32'(phase), 32'(P_LOSE));
    check("lose_lives", 32'(lives), 0);
    start = 1'b1;
    tick();
    check("lose_to_idle", 32'(phase), 32'(P_IDLE));
    tick();
    check("relaunch_gen", 32'(phase), 32'(P_GEN));
    check("relaunch_lives", 32'(lives), 1);
    check("relaunch_level", 32'(lvl_o), 0);
    start = 1'b0;

    // A: level 2 mismatch on step 0
    sel = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    do_round(1);
    check("a_gen2", 32'(phase), 32'(P_GEN));
    tick();
    blinker_done = 1'b1;
    tick();
    blinker_done = 1'b0;
    input_done = 1'b1;
    tick();
    input_done = 1'b0;
    check("a_val_lives", 32'(lives), 3);
    snap = a_gen_cnt;
    cmp_good = 1'b0;
    tick();
    cmp_good = 1'b1;
    check("mis_phase", 32'(phase), 32'(P_BLINK));
    check("mis_lives", 32'(lives), 2);
    check("mis_level", 32'(lvl_o), 2);
    check("mis_step",  32'(stp), 0);
    blinker_done = 1'b1;
    tick();
    blinker_done = 1'b0;
    check("mis_no_gen", a_gen_cnt - snap, 0);

    // A: timeout at step 1
    input_done = 1'b1;
    tick();
    input_done = 1'b0;
    tick();
    check("to_step1", 32'(stp), 1);
    check("to_addr1", 32'(addr), 1);
    for (int i = 0; i < 5; i++) begin
      check("to_in_phase", 32'(phase), 32'(P_INPUT));
      check("to_err", 32'(tmo), (i == 4) ? 1 : 0);
      tick();
    end
    check("to_blink", 32'(phase), 32'(P_BLINK));
    check("to_lives", 32'(lives), 1);
    check("to_step0", 32'(stp), 0);
    check("to_level", 32'(lvl_o), 2);

    // A: input_done coincides with the last timer cycle
    blinker_done = 1'b1;
    tick();
    blinker_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("race_no_err", 32'(tmo), 0);
      tick();
    end
    input_done = 1'b1;
    #1;
    check("race_err_masked", 32'(tmo), 0);
    tick();
    input_done = 1'b0;
    check("race_val", 32'(phase), 32'(P_VAL));
    check("race_lives", 32'(lives), 1);
    tick();
    input_done = 1'b1;
    tick();
    input_done = 1'b0;
    tick();
    do_round(3);
    tick();
    blinker_done = 1'b1;
    tick();
    blinker_done = 1'b0;
    check("l4_input", 32'(phase), 32'(P_INPUT));
    check("l4_level", 32'(lvl_o), 4);
    tick();
    tick();

    // A: asynchronous reset mid-INPUT
    #2 reset = 1'b0;
    #1;
    check("arst_phase", 32'(phase), 32'(P_IDLE));
    check("arst_addr",  32'(addr), 0);
    check("arst_level", 32'(lvl_o), 0);
    check("arst_step",  32'(stp), 0);
    check("arst_lives", 32'(lives), 3);
    check("arst_tmo",   32'(tmo), 0);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arst_idle_hold", 32'(phase), 32'(P_IDLE));
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("arst_restart", 32'(phase), 32'(P_GEN));
    check("arst_restart_lives", 32'(lives), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
